// File: rtl/run_detect_sequencer.sv
// Stimulus sequencer for a serial 4-run detector.
// Replays a latched pattern MSB-first at one bit per tick and counts detector hits.
module run_detect_sequencer #(
    parameter int DIV_COUNT = 125000000,
    parameter int PAT_W     = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] rep_count,
    input  logic             det_out,
    output logic             det_in,
    output logic             det_ce,
    output logic             det_rst,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_count
);

    localparam int DW = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
    localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [DW-1:0]    div_cnt;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] sh_q;
    logic [CNT_W-1:0] reps_q;
    logic [CNT_W-1:0] rep_idx;
    logic [IW-1:0]    idx;
    logic             prev_out;
    logic             tick;
    logic             last_bit;
    logic             last_rep;
    logic             rise;

    assign tick     = (div_cnt == DW'(DIV_COUNT - 1));
    assign det_ce   = tick & busy;
    assign last_bit = (idx == IW'(PAT_W - 1));
    assign last_rep = (rep_idx == reps_q - CNT_W'(1));
    assign rise     = det_out & ~prev_out & (hit_count != {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            pat_q     <= '0;
            sh_q      <= '0;
            reps_q    <= '0;
            rep_idx   <= '0;
            idx       <= '0;
            prev_out  <= 1'b0;
            det_in    <= 1'b0;
            det_rst   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit_count <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            // abort wins over a coincident tick: no sample, no done
            if (state != IDLE && abort) begin
                state   <= IDLE;
                busy    <= 1'b0;
                div_cnt <= '0;
                det_in  <= 1'b0;
                det_rst <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            pat_q     <= pattern;
                            reps_q    <= (rep_count == '0) ? CNT_W'(1) : rep_count;
                            hit_count <= '0;
                            idx       <= '0;
                            rep_idx   <= '0;
                            prev_out  <= 1'b0;
                            state     <= CLEAR;
                            busy      <= 1'b1;
                            det_rst   <= 1'b1;
                            det_in    <= 1'b0;
                        end
                    end
                    CLEAR: begin
                        if (tick) begin
                            state   <= SHIFT;
                            det_rst <= 1'b0;
                            det_in  <= pat_q[PAT_W-1];
                            sh_q    <= pat_q << 1;
                        end
                    end
                    SHIFT: begin
                        if (tick) begin
                            if (rise) hit_count <= hit_count + CNT_W'(1);
                            prev_out <= det_out;
                            if (!last_bit) begin
                                idx    <= idx + IW'(1);
                                det_in <= sh_q[PAT_W-1];
                                sh_q   <= sh_q << 1;
                            end else if (!last_rep) begin
                                idx     <= '0;
                                rep_idx <= rep_idx + CNT_W'(1);
                                det_in  <= pat_q[PAT_W-1];
                                sh_q    <= pat_q << 1;
                            end else begin
                                idx    <= '0;
                                state  <= DRAIN;
                                det_in <= 1'b0;
                            end
                        end
                    end
                    DRAIN: begin
                        if (tick) begin
                            if (rise) hit_count <= hit_count + CNT_W'(1);
                            prev_out <= det_out;
                            state    <= DONE;
                            done     <= 1'b1;
                        end
                    end
                    DONE: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        div_cnt <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_run_detect_sequencer.sv
// Bench for run_detect_sequencer with an in-bench 4-run detector.
// Outputs are compared every cycle against a timeline model of the run.
module tb_run_detect_sequencer;

    localparam int DIV  = 4;
    localparam int MAXN = 1100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] pattern;
    logic [7:0]  rep_count;
    logic        det_out;
    logic        det_in;
    logic        det_ce;
    logic        det_rst;
    logic        busy;
    logic        done;
    logic [7:0]  hit_count;

    run_detect_sequencer #(
        .DIV_COUNT(DIV),
        .PAT_W(16),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .pattern(pattern),
        .rep_count(rep_count),
        .det_out(det_out),
        .det_in(det_in),
        .det_ce(det_ce),
        .det_rst(det_rst),
        .busy(busy),
        .done(done),
        .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    // serial detector: out=1 once the last four bits are equal
    logic [2:0] d_run;
    logic       d_last;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_run   <= '0;
            d_last  <= 1'b0;
            det_out <= 1'b0;
        end else if (det_ce) begin
            if (det_rst) begin
                d_run   <= '0;
                d_last  <= 1'b0;
                det_out <= 1'b0;
            end else begin
                d_last <= det_in;
                if (d_run != 3'd0 && det_in == d_last) begin
                    d_run   <= (d_run == 3'd4) ? 3'd4 : d_run + 3'd1;
                    det_out <= (d_run >= 3'd3);
                end else begin
                    d_run   <= 3'd1;
                    det_out <= 1'b0;
                end
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    bit m_active = 1'b0;
    int m_t = 0;
    int m_n = 0;
    int m_last = 0;
    int m_hits = 0;
    bit seq [0:MAXN];
    int hits_after [0:MAXN+1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic build(input logic [15:0] pat, input logic [7:0] rep);
        int r;
        int h;
        bit prev;
        bit o;
        r = (rep == 8'd0) ? 1 : int'(rep);
        m_n = 16 * r;
        m_last = (m_n + 2) * DIV + 1;
        for (int k = 0; k < m_n; k++) seq[k] = pat[15 - (k % 16)];
        prev = 1'b0;
        h = 0;
        hits_after[0] = 0;
        for (int m = 0; m <= m_n; m++) begin
            o = (m >= 4) && seq[m-1] == seq[m-2] && seq[m-2] == seq[m-3] && seq[m-3] == seq[m-4];
            if (o && !prev && h < 255) h++;
            prev = o;
            hits_after[m+1] = h;
        end
    endtask

    function automatic int vis(input int t);
        int s;
        s = (t - 1) / DIV - 1;
        if (s < 0) s = 0;
        if (s > m_n + 1) s = m_n + 1;
        return hits_after[s];
    endfunction

    task automatic model_edge();
        if (!m_active) begin
            if (start) begin
                build(pattern, rep_count);
                m_active = 1'b1;
                m_t = 1;
                m_hits = 0;
            end
        end else if (abort) begin
            m_hits = vis(m_t);
            m_active = 1'b0;
        end else if (m_t == m_last) begin
            m_hits = hits_after[m_n+1];
            m_active = 1'b0;
        end else begin
            m_t++;
        end
    endtask

    task automatic compare();
        int p;
        logic e_busy, e_ce, e_rst, e_in, e_done;
        int e_hit;
        e_busy = 1'b0; e_ce = 1'b0; e_rst = 1'b0;
        e_in = 1'b0; e_done = 1'b0; e_hit = m_hits;
        if (m_active) begin
            e_busy = 1'b1;
            if (m_t == m_last) begin
                e_done = 1'b1;
                e_hit = hits_after[m_n+1];
            end else begin
                p = (m_t - 1) / DIV;
                e_ce = ((m_t - 1) % DIV) == DIV - 1;
                e_rst = (p == 0);
                e_in = (p >= 1 && p <= m_n) ? seq[p-1] : 1'b0;
                e_hit = vis(m_t);
            end
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("det_ce", 32'(det_ce), 32'(e_ce));
        chk("det_rst", 32'(det_rst), 32'(e_rst));
        chk("det_in", 32'(det_in), 32'(e_in));
        chk("done", 32'(done), 32'(e_done));
        chk("hit_count", 32'(hit_count), 32'(e_hit));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input logic [15:0] pat, input logic [7:0] rep,
                       input int abort_at, input int restart_at,
                       output int done_at, output int ce_n);
        int c;
        done_at = -1;
        ce_n = 0;
        start = 1'b1;
        pattern = pat;
        rep_count = rep;
        cyc();
        start = 1'b0;
        pattern = 16'($urandom);
        rep_count = 8'($urandom);
        c = 1;
        while (busy) begin
            if (det_ce && !det_rst) ce_n++;
            if (done) done_at = c;
            start = (c == restart_at);
            abort = (c == abort_at);
            if (c > 6000) begin
                chk("run_timeout", 32'(c), 32'd6000);
                break;
            end
            cyc();
            c++;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int d;
        int ce;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        pattern = '0;
        rep_count = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ce", 32'(det_ce), 32'd0);
        chk("rst_det_rst", 32'(det_rst), 32'd0);
        chk("rst_hits", 32'(hit_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        cyc();

        run(16'h0F00, 8'd1, -1, -1, d, ce);
        chk("done_at_0F00", 32'(d), 32'd73);
        chk("hits_0F00", 32'(hit_count), 32'd3);
        chk("model_0F00", 32'(m_hits), 32'd3);

        run(16'hAAAA, 8'd3, -1, -1, d, ce);
        chk("done_at_AAAA", 32'(d), 32'd201);
        chk("shift_ce_AAAA", 32'(ce - 1), 32'd48);
        chk("hits_AAAA", 32'(hit_count), 32'd0);

        run(16'hFFFF, 8'd0, -1, -1, d, ce);
        chk("hits_FFFF", 32'(hit_count), 32'd1);
        chk("model_FFFF", 32'(m_hits), 32'd1);

        run(16'hF0F0, 8'd64, -1, -1, d, ce);
        chk("hits_sat", 32'(hit_count), 32'd255);
        chk("model_sat", 32'(m_hits), 32'd255);

        run(16'h0F00, 8'd1, -1, 30, d, ce);
        chk("restart_ignored", 32'(hit_count), 32'd3);

        run(16'h0F00, 8'd1, 6 * DIV + 2, -1, d, ce);
        chk("abort_no_done", 32'(d), 32'hFFFF_FFFF);
        chk("abort_hits", 32'(hit_count), 32'd1);

        start = 1'b1;
        pattern = 16'h0F00;
        rep_count = 8'd1;
        cyc();
        start = 1'b0;
        repeat (29) cyc();
        reset = 1'b0;
        #1;
        m_active = 1'b0;
        m_hits = 0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ce", 32'(det_ce), 32'd0);
        chk("mid_rst_hits", 32'(hit_count), 32'd0);
        chk("mid_rst_det_rst", 32'(det_rst), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        run(16'h0F00, 8'd1, -1, -1, d, ce);
        chk("post_rst_done_at", 32'(d), 32'd73);
        chk("post_rst_hits", 32'(hit_count), 32'd3);

        for (int i = 0; i < 14; i++) begin
            int ab;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 150)) : -1;
            run(16'($urandom), 8'($urandom_range(0, 3)), ab,
                int'($urandom_range(2, 80)), d, ce);
            repeat ($urandom_range(0, 3)) cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
